// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp
// Output stage behind the iterative CORDIC datapath. It captures one raw
// (x, y, angle) vector and scales x and y by the gain-correction constant K.
// A shift-add multiplier handles one bit of K per cycle, with x and y in
// parallel. The angle passes through bit-exact. Both sides use valid/ready.
module cordic_gain_comp #(
    parameter int                   BIT_WIDTH       = 32,
    parameter int                   LOG_2_BIT_WIDTH = 5,
    parameter logic [BIT_WIDTH-1:0] K               = 32'h26DD3B6A
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_x,
    input  logic [BIT_WIDTH-1:0] in_y,
    input  logic [BIT_WIDTH-1:0] in_angle,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_x,
    output logic [BIT_WIDTH-1:0] out_y,
    output logic [BIT_WIDTH-1:0] out_angle
);

    localparam int ACC_W = 2 * BIT_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [LOG_2_BIT_WIDTH-1:0] CNT_LAST = LOG_2_BIT_WIDTH'(BIT_WIDTH - 1);

    localparam logic [BIT_WIDTH-1:0] SAT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] SAT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    logic [1:0]                 state;
    logic [LOG_2_BIT_WIDTH-1:0] cnt;
    logic [BIT_WIDTH-1:0]       x_reg;
    logic [BIT_WIDTH-1:0]       y_reg;
    logic [BIT_WIDTH-1:0]       angle_reg;
    logic signed [ACC_W-1:0]    acc_x;
    logic signed [ACC_W-1:0]    acc_y;
    logic signed [ACC_W-1:0]    acc_x_next;
    logic signed [ACC_W-1:0]    acc_y_next;
    logic signed [ACC_W-1:0]    x_ext;
    logic signed [ACC_W-1:0]    y_ext;
    logic                       k_bit;
    logic                       accept;
    logic                       last_step;
    logic                       release_out;

    // Take the accumulator back to Q2 by dropping the fraction bits below the
    // binary point of K. The shift floors toward -inf. If the upper bits
    // disagree with the sign, the value is out of range and is clamped.
    function automatic logic [BIT_WIDTH-1:0] scale_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> (BIT_WIDTH - 2);
        if (&shifted[ACC_W-1:BIT_WIDTH-1] || ~|shifted[ACC_W-1:BIT_WIDTH-1]) begin
            scale_sat = shifted[BIT_WIDTH-1:0];
        end else if (shifted[ACC_W-1]) begin
            scale_sat = SAT_MIN;
        end else begin
            scale_sat = SAT_MAX;
        end
    endfunction

    // Handshake flags are pure decodes of the state register.
    assign in_ready    = (state == ST_IDLE);
    assign out_valid   = (state == ST_DONE);
    assign accept      = in_valid && in_ready;
    assign last_step   = (state == ST_MULT) && (cnt == CNT_LAST);
    assign release_out = out_valid && out_ready;

    // Form this cycle's partial products and the accumulator values after the add.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        x_ext      = {{BIT_WIDTH{x_reg[BIT_WIDTH-1]}}, x_reg};
        y_ext      = {{BIT_WIDTH{y_reg[BIT_WIDTH-1]}}, y_reg};
        k_bit      = K[cnt];
        acc_x_next = acc_x;
        acc_y_next = acc_y;
        if (k_bit) begin
            acc_x_next = acc_x + (x_ext <<< cnt);
            acc_y_next = acc_y + (y_ext <<< cnt);
        end
    end

    // Control FSM: IDLE accepts a vector, MULT walks the bits of K, DONE holds the result.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers are written with <= so all state updates together at the edge.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept)      state <= ST_MULT;
                ST_MULT: if (last_step)   state <= ST_DONE;
                ST_DONE: if (release_out) state <= ST_IDLE;
                default:                  state <= ST_IDLE;
            endcase
        end
    end

    // Bit counter into K. It restarts at each accept and advances once per MULT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == ST_MULT) begin
            cnt <= last_step ? '0 : cnt + 1'b1;
        end
    end

    // Input capture. Operands are sampled only on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the async reset clears every register, so a reset in MULT or DONE drops the vector cleanly.
        if (!rst_n) begin
            x_reg     <= '0;
            y_reg     <= '0;
            angle_reg <= '0;
        end else if (accept) begin
            x_reg     <= in_x;
            y_reg     <= in_y;
            angle_reg <= in_angle;
        end
    end

    // Accumulators. They clear on accept and add one partial product per MULT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_x <= '0;
            acc_y <= '0;
        end else if (accept) begin
            acc_x <= '0;
            acc_y <= '0;
        end else if (state == ST_MULT) begin
            acc_x <= acc_x_next;
            acc_y <= acc_y_next;
        end
    end

    // Result registers. They load on the final add and otherwise hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_x     <= '0;
            out_y     <= '0;
            out_angle <= '0;
        end else if (last_step) begin
            out_x     <= scale_sat(acc_x_next);
            out_y     <= scale_sat(acc_y_next);
            out_angle <= angle_reg;
        end
    end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// tb_cordic_gain_comp
// Scoreboard bench for the CORDIC gain-compensation stage. The driver pushes
// expected results from a reference multiply-and-floor model. The monitor
// pops an entry and compares it on each output handshake. A second instance
// with K near 2.0 exercises saturation.
module tb_cordic_gain_comp;

    localparam logic [31:0] KDEF = 32'h26DD3B6A;
    localparam logic [31:0] KMAX = 32'h7FFFFFFF;
    localparam longint      SMAX = 64'sd2147483647;
    localparam longint      SMIN = -64'sd2147483648;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] a;
        int unsigned acc_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [31:0] in_angle;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_angle;

    logic        k_in_valid;
    logic        k_in_ready;
    logic [31:0] k_in_x;
    logic [31:0] k_in_y;
    logic [31:0] k_in_angle;
    logic        k_out_valid;
    logic        k_out_ready;
    logic [31:0] k_out_x;
    logic [31:0] k_out_y;
    logic [31:0] k_out_angle;

    int          n_vec;
    int          n_err;
    int          n_out;
    int unsigned cyc;
    int unsigned last_acc;
    logic        spacing_check;
    logic        prev_ov;
    exp_t        sb[$];

    cordic_gain_comp #(.BIT_WIDTH(32), .LOG_2_BIT_WIDTH(5), .K(KDEF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_angle  (in_angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_angle (out_angle)
    );

    cordic_gain_comp #(.BIT_WIDTH(32), .LOG_2_BIT_WIDTH(5), .K(KMAX)) dut_kmax (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (k_in_valid),
        .in_ready  (k_in_ready),
        .in_x      (k_in_x),
        .in_y      (k_in_y),
        .in_angle  (k_in_angle),
        .out_valid (k_out_valid),
        .out_ready (k_out_ready),
        .out_x     (k_out_x),
        .out_y     (k_out_y),
        .out_angle (k_out_angle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision signed product, floor by 2**30, then clamp to 32 bits.
    function automatic logic [31:0] model(input logic [31:0] v, input logic [31:0] k);
        longint sv;
        longint kv;
        longint s;
        sv = longint'($signed(v));
        kv = longint'({32'h0, k});
        s  = (sv * kv) >>> 30;
        if (s > SMAX) return 32'h7FFFFFFF;
        if (s < SMIN) return 32'h80000000;
        return s[31:0];
    endfunction

    // Output monitor. It checks latency when out_valid rises and pops the scoreboard on each handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov && sb.size() > 0)
                check("latency", 64'(cyc - sb[0].acc_cyc), 64'd32);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_x", 64'(out_x), 64'(e.x));
                    check("out_y", 64'(out_y), 64'(e.y));
                    check("out_angle", 64'(out_angle), 64'(e.a));
                    n_out++;
                end
            end
            prev_ov = out_valid;
        end
    end

    // Call at a negedge. Drives a vector, waits for acceptance, and returns one negedge after the accept edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] a);
        int t;
        in_x = x; in_y = y; in_angle = a; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{model(x, KDEF), model(y, KDEF), a, cyc + 1});
        if (spacing_check && last_acc != 0)
            check("accept_spacing", 64'(cyc + 1 - last_acc), 64'd34);
        last_acc = cyc + 1;
        @(negedge clk);
    endtask

    // Drop in_valid and scramble the input bus. The DUT must ignore these values.
    task automatic idle_inputs();
        in_valid = 1'b0;
        in_x = $urandom; in_y = $urandom; in_angle = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic ksend(input logic [31:0] x, input logic [31:0] y);
        int t;
        k_in_x = x; k_in_y = y; k_in_angle = x ^ y; k_in_valid = 1'b1;
        t = 0;
        while (!k_in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        k_in_valid = 1'b0;
        t = 0;
        while (!k_out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!k_out_valid) begin
            check("kmax_timeout", 64'd0, 64'd1);
        end else begin
            check("kmax_x", 64'(k_out_x), 64'(model(x, KMAX)));
            check("kmax_y", 64'(k_out_y), 64'(model(y, KMAX)));
            check("kmax_angle", 64'(k_out_angle), 64'(x ^ y));
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int t;
        int n_before;
        logic [31:0] ex;
        logic [31:0] ey;
        n_vec = 0; n_err = 0; n_out = 0; cyc = 0; last_acc = 0;
        spacing_check = 1'b0; prev_ov = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_x = '0; in_y = '0; in_angle = '0;
        k_in_valid = 1'b0; k_out_ready = 1'b1;
        k_in_x = '0; k_in_y = '0; k_in_angle = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_x", 64'(out_x), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_angle", 64'(out_angle), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: x = 1.0 gives K itself
        send(32'h40000000, 32'h0, 32'h12345678);
        idle_inputs();
        drain();
        check("t1_out_x_const", 64'(out_x), 64'h26DD3B6A);
        check("t1_out_y_const", 64'(out_y), 64'h0);
        check("t1_hold_valid", 64'(out_valid), 64'd0);

        // 2: negative x, floored y
        send(32'hC0000000, 32'h20000000, 32'hDEADBEEF);
        idle_inputs();
        drain();
        check("t2_out_x_const", 64'(out_x), 64'hD922C496);
        check("t2_out_y_const", 64'(out_y), 64'h136E9DB5);

        // A few random vectors. Odd negatives exercise the floor.
        for (int i = 0; i < 4; i++) begin
            send($urandom, $urandom, $urandom);
            idle_inputs();
            drain();
        end
        send(32'hFFFFFFFF, 32'h80000001, 32'h0);
        idle_inputs();
        drain();

        // 3: backpressure
        out_ready = 1'b0;
        ex = model(32'h3A5A5A5A, KDEF);
        ey = model(32'hB1234567, KDEF);
        send(32'h3A5A5A5A, 32'hB1234567, 32'hCAFEF00D);
        idle_inputs();
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_x", 64'(out_x), 64'(ex));
            check("bp_out_y", 64'(out_y), 64'(ey));
            check("bp_out_angle", 64'(out_angle), 64'hCAFEF00D);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_rel_in_ready", 64'(in_ready), 64'd1);
        check("bp_rel_out_valid", 64'(out_valid), 64'd0);
        check("bp_rel_hold_x", 64'(out_x), 64'(ex));
        check("bp_queue_empty", 64'(sb.size()), 64'd0);

        // 4: reset 10 cycles into MULT
        send(32'h12345678, 32'h87654321, 32'h0BADF00D);
        idle_inputs();
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_x", 64'(out_x), 64'd0);
        check("mid_rst_out_y", 64'(out_y), 64'd0);
        check("mid_rst_out_angle", 64'(out_angle), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h40000000, 32'hE0000000, 32'h55AA55AA);
        idle_inputs();
        drain();

        // 5: saturation with K near 2.0
        ksend(32'h7FFFFFFF, 32'h80000000);
        check("sat_pos", 64'(k_out_x), 64'h7FFFFFFF);
        check("sat_neg", 64'(k_out_y), 64'h80000000);
        ksend(32'h80000000, 32'h10000000);
        check("sat_neg_x", 64'(k_out_x), 64'h80000000);

        // 6: three back-to-back vectors with in_valid held high
        n_before = n_out;
        spacing_check = 1'b1;
        last_acc = 0;
        send(32'h11111111, 32'h22222222, 32'h00000001);
        send(32'hF0000000, 32'h0FFFFFFF, 32'h00000002);
        send(32'h7FFFFFFF, 32'h80000000, 32'h00000003);
        idle_inputs();
        spacing_check = 1'b0;
        drain();
        check("b2b_count", 64'(n_out - n_before), 64'd3);
        check("final_queue_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
